ins_sequencer: RTL

INS_SEQUENCER -- requirements
Module: ins_sequencer

---
 rtl/ins_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/ins_sequencer.sv
// ins_sequencer: steps through a loaded program buffer, holding each instruction on codigo for a per-class number of cycles.
module ins_sequencer #(
  parameter int DEPTH    = 16,
  parameter int HOLD_ALU = 2,
  parameter int HOLD_MEM = 3,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic [AW-1:0] carga_dir,
  input  logic [31:0]   carga_dato,
  input  logic          inicio,
  input  logic          cero,
  output logic [31:0]   codigo,
  output logic          valido,
  output logic [AW-1:0] pc,
  output logic          ocupado,
  output logic          fin,
  output logic          error,
  output logic [AW:0]   num_cero
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [31:0] word;
  logic [7:0]  hold;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        alu;
  logic        mm;
  assign ocupado = state != IDLE;
  assign word    = mem[pc];
  assign op      = word[31:26];
  assign fn      = word[5:0];
  assign alu     = (op == 6'b000000 && fn >= 6'd1 && fn <= 6'd4) ||
                   op == 6'b001000 || op == 6'b001100 || op == 6'b001101;
  assign mm      = op == 6'b100110 || op == 6'b101011;
  // The buffer has no reset; it is reloaded after every reset.
  always_ff @(posedge clk)
    if (carga && !ocupado) mem[carga_dir] <= carga_dato;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      codigo   <= '0;
      valido   <= 1'b0;
      fin      <= 1'b0;
      error    <= 1'b0;
      num_cero <= '0;
      hold     <= '0;
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE: if (inicio) begin
          pc       <= '0;
          error    <= 1'b0;
          num_cero <= '0;
          state    <= FETCH;
        end
        FETCH: if (word == 32'd0) begin
          state <= DONE;
          fin   <= 1'b1;
        end else if (alu || mm) begin
          state  <= EXEC;
          codigo <= word;
          valido <= 1'b1;
          hold   <= mm ? 8'(HOLD_MEM) : 8'(HOLD_ALU);
        end else begin
          state <= DONE;
          fin   <= 1'b1;
          error <= 1'b1;
        end
        EXEC: if (hold > 8'd1) hold <= hold - 8'd1;
        else begin
          hold     <= '0;
          codigo   <= '0;
          valido   <= 1'b0;
          num_cero <= (cero && num_cero != '1) ? num_cero + 1'b1 : num_cero;
          // The last word ends the program rather than wrapping to address 0.
          if (pc == AW'(DEPTH - 1)) begin
            state <= DONE;
            fin   <= 1'b1;
          end else begin
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule
